// File: rtl/jk_counter_pkg.sv
// Shared JK flip-flop encodings, packed as {j, k}.
// The other flip-flop blocks and their benches reuse these.
package jk_counter_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_counter_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
// The counter instantiates one of these per bit.
module jk_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: q <= q;
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        default: q <= ~q;
      endcase
    end
  end

  assign q_bar = ~q;

endmodule

// File: rtl/jk_counter.sv
// Up/down counter built from JK cells, with parallel load, count enable,
// wrap or saturate mode, and terminal-count and wrap flags.
module jk_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             wrap
);

  localparam logic SAT = (SATURATE != 0);

  logic [WIDTH-1:0] match;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [1:0]       cmd [WIDTH];

  assign tc    = up ? (&q) : ~(|q);
  assign match = up ? q : ~q;

  // Bit i toggles when every lower bit is at its carry/borrow value.
  always_comb begin
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = &(match | ~((WIDTH'(1) << i) - WIDTH'(1)));
    end
  end

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        cmd[i] = d[i] ? JK_SET : JK_RST;
      end else if (en && !(tc && SAT) && t[i]) begin
        cmd[i] = JK_TOG;
      end else begin
        cmd[i] = JK_HOLD;
      end
      j[i] = cmd[i][1];
      k[i] = cmd[i][0];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g]),
      .q_bar (q_bar[g])
    );
  end

  // Registered on the wrapping edge, so it is high while q shows the wrapped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= en && !load && tc && !SAT;
    end
  end

endmodule
